// File: rtl/reg19_arb_pkg.sv
// Shared definitions for the 19-bit register access arbiter: op codes,
// FSM encoding and the op-to-control-line decoder.
package reg19_arb_pkg;

  localparam int DATA_W_DEF = 19;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  typedef struct packed {
    logic clr;
    logic dec;
    logic inc;
    logic load;
  } ctl_t;

  function automatic ctl_t op_decode(input logic [1:0] op);
    ctl_t c;
    c = '0;
    case (op)
      OP_LOAD: c.load = 1'b1;
      OP_INC:  c.inc  = 1'b1;
      OP_DEC:  c.dec  = 1'b1;
      default: c.clr  = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg19_access_arbiter_rr_pick.sv
// Combinational round-robin find-first: lowest set request strictly above
// rr_last wins, otherwise wrap to the lowest set request overall.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [NUM_REQ-1:0] win_oh,
  output logic               valid
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] req_hi;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) hi_mask[i] = (i > int'(rr_last));
  end

  // x & -x isolates the lowest set bit
  always_comb begin
    req_hi = req & hi_mask;
    if (|req_hi) win_oh = req_hi & (~req_hi + NUM_REQ'(1));
    else         win_oh = req & (~req + NUM_REQ'(1));
    valid = |req;
  end

endmodule

// File: rtl/reg19_access_arbiter.sv
// Round-robin arbiter sharing one 19-bit register's LOAD/INC/DEC/CLR port.
// Optional macro ARB_LOCK_EN adds req_lock for bursts of up to MAX_BURST ops.
module reg19_access_arbiter
  import reg19_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      done,
  output logic                      busy,
  output logic                      LOAD,
  output logic                      INC,
  output logic                      DEC,
  output logic                      CLR,
  output logic [DATA_W-1:0]         inpData
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = $clog2(MAX_BURST) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
    $error("reg19_access_arbiter: NUM_REQ must be 2..8 and MAX_BURST >= 1");
  end

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  ctl_t                ctl_q, ctl_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    rr_last_q, rr_last_d;
`ifdef ARB_LOCK_EN
  logic [BURST_W-1:0]  burst_q, burst_d;
`endif

  logic [NUM_REQ-1:0]  win_oh;
  logic                win_vld;
  logic [NUM_REQ-1:0]  sel_oh;
  logic [1:0]          sel_op;
  logic [DATA_W-1:0]   sel_data;
  logic [IDX_W-1:0]    sel_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .win_oh  (win_oh),
    .valid   (win_vld)
  );

  // In IDLE the new winner is selected; in DONE a locked burst re-reads the owner.
  always_comb begin
    sel_oh   = (state_q == ST_IDLE) ? win_oh : gnt_q;
    sel_op   = '0;
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_oh[i]) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[DATA_W*i +: DATA_W];
        sel_idx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = 1'b0;
    ctl_d     = '0;
    data_d    = data_q;
    rr_last_d = rr_last_q;
`ifdef ARB_LOCK_EN
    burst_d   = burst_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          gnt_d     = win_oh;
          ctl_d     = op_decode(sel_op);
          data_d    = sel_data;
          rr_last_d = sel_idx;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
`ifdef ARB_LOCK_EN
        if (|(gnt_q & req & req_lock) && burst_q < BURST_W'(MAX_BURST - 1)) begin
          ctl_d   = op_decode(sel_op);
          data_d  = sel_data;
          burst_d = burst_q + BURST_W'(1);
          state_d = ST_ISSUE;
        end else begin
          gnt_d   = '0;
          burst_d = '0;
          state_d = ST_IDLE;
        end
`else
        gnt_d   = '0;
        state_d = ST_IDLE;
`endif
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ctl_q     <= '0;
      data_q    <= '0;
      rr_last_q <= IDX_W'(NUM_REQ - 1);
`ifdef ARB_LOCK_EN
      burst_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ctl_q     <= ctl_d;
      data_q    <= data_d;
      rr_last_q <= rr_last_d;
`ifdef ARB_LOCK_EN
      burst_q   <= burst_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign LOAD    = ctl_q.load;
  assign INC     = ctl_q.inc;
  assign DEC     = ctl_q.dec;
  assign CLR     = ctl_q.clr;
  assign inpData = data_q;

endmodule
